// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequences byte/halfword/word loads and stores onto a single-port
// 1024-word memory that has combinational read data. Loads take one
// memory cycle. Word stores write directly. Sub-word stores read the
// word, merge the new lane into it, then write the merged word back.
// Requests that are misaligned or that fall outside the 4 KiB window
// end with an error pulse and do not touch memory.
//
// Ports
//   clk      : rising-edge clock
//   reset    : synchronous, active-high reset
//   req      : access request, sampled only while ready is high
//   op[2:0]  : 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
//   addr     : byte address
//   wdata    : store data (SH uses [15:0], SB uses [7:0])
//   pc_in    : PC of the requesting instruction
//   ready    : high while idle and able to accept a request
//   done     : one-cycle completion pulse, also raised on error
//   rdata    : extended load result, held until the next load completes
//   addr_err : one-cycle error pulse, coincident with done
//   dm_pc    : registered pc_in, used by the memory for write logging
//   dm_we    : memory write enable
//   dm_addr  : word index into the memory
//   dm_din   : word written to memory
//   dm_dout  : combinational memory read data for dm_addr
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc_in,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic [31:0] dm_pc,
  output logic        dm_we,
  output logic [9:0]  dm_addr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;

  typedef enum logic [2:0] {IDLE, LD, RD, WR, ERR} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        addr_err_q, addr_err_d;
  logic        dm_we_q, dm_we_d;

  logic        req_is_load;
  logic        req_is_word;
  logic        req_is_half;
  logic        req_bad;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Only the low 12 address bits are kept; anything above them is
  // rejected here, before acceptance.
  always_comb begin
    req_is_load = (op <= OP_LBU);
    req_is_word = (op == OP_LW) || (op == OP_SW);
    req_is_half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    req_bad     = (addr[31:12] != 20'd0)
                || (req_is_word && (addr[1:0] != 2'b00))
                || (req_is_half && addr[0]);
  end

  // Lane extraction for loads and lane insertion for sub-word stores.
  // din_q still holds the raw store data while in RD.
  always_comb begin
    lane_half = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];
    case (addr_q[1:0])
      2'd0:    lane_byte = dm_dout[7:0];
      2'd1:    lane_byte = dm_dout[15:8];
      2'd2:    lane_byte = dm_dout[23:16];
      default: lane_byte = dm_dout[31:24];
    endcase

    case (op_q)
      OP_LH:   load_val = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_val = {16'd0, lane_half};
      OP_LB:   load_val = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_val = {24'd0, lane_byte};
      default: load_val = dm_dout;
    endcase

    merged = dm_dout;
    if (op_q == OP_SH) begin
      if (addr_q[1]) merged[31:16] = din_q[15:0];
      else           merged[15:0]  = din_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = din_q[7:0];
        2'd1:    merged[15:8]  = din_q[7:0];
        2'd2:    merged[23:16] = din_q[7:0];
        default: merged[31:24] = din_q[7:0];
      endcase
    end
  end

  // done, addr_err and dm_we are computed one state ahead so that the
  // registered copies line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    din_d      = din_q;
    pc_d       = pc_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    addr_err_d = 1'b0;
    dm_we_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          op_d   = op;
          addr_d = addr[11:0];
          din_d  = wdata;
          pc_d   = pc_in;
          if (req_bad) begin
            state_d    = ERR;
            done_d     = 1'b1;
            addr_err_d = 1'b1;
          end else if (req_is_load) begin
            state_d = LD;
          end else if (op == OP_SW) begin
            state_d = WR;
            dm_we_d = 1'b1;
          end else begin
            state_d = RD;
          end
        end
      end
      LD: begin
        rdata_d = load_val;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      RD: begin
        din_d   = merged;
        dm_we_d = 1'b1;
        state_d = WR;
      end
      WR: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= 3'd0;
      addr_q     <= 12'd0;
      din_q      <= 32'd0;
      pc_q       <= 32'd0;
      rdata_q    <= 32'd0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      dm_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      pc_q       <= pc_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      addr_err_q <= addr_err_d;
      dm_we_q    <= dm_we_d;
    end
  end

  // The write enable is also masked by reset directly, so a reset that
  // lands during WR suppresses the write at that same edge.
  assign dm_we    = dm_we_q & ~reset;
  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign addr_err = addr_err_q;
  assign rdata    = rdata_q;
  assign dm_pc    = pc_q;
  assign dm_addr  = addr_q[11:2];
  assign dm_din   = din_q;

endmodule
